pipe_issue_ctrl: RTL and testbench
==================================

Name: pipe_issue_ctrl

Overview:
- Issue controller and arbiter in front of the 4-stage register-ALU-writeback-store pipeline.
- Two requesters share the pipeline; grants alternate round-robin.
- A scoreboard of in-flight destinations holds back read-after-write hazards.
- Illegal func codes are dropped and counted; one issue per cycle drives the pipeline's rs1/rs2/rd/func/addr inputs.

Parameters:
- INSTR_W, 24, packed instruction width: func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0].
- WB_LAT, 3, cycles after acceptance during which an instruction's rd is unreadable (scoreboard depth, 1..8).
- CNT_W, 16, width of the issue and error counters.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an instruction.
- req0_instr  in  INSTR_W  requester 0 packed instruction; stable while valid && !ready.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid  in  1  requester 1 has an instruction.
- req1_instr  in  INSTR_W  requester 1 packed instruction; stable while valid && !ready.
- req1_ready  out  1  requester 1 accepted this cycle.
- hold  in  1  suppresses all acceptance while high.
- iss_valid  out  1  issue strobe to pipeline.
- iss_rs1, iss_rs2, iss_rd, iss_func  out  4 each  issued fields.
- iss_addr  out  8  issued memory address.
- iss_src  out  1  requester index of issued instruction.
- busy  out  1  iss_valid or any scoreboard entry valid.
- err_pulse  out  1  one-cycle pulse when an illegal instruction is dropped.
- issue_cnt  out  CNT_W  total issued, wraps.
- err_cnt  out  CNT_W  total dropped, saturates at all-ones.

Behaviour:
- Reset: all outputs are 0, rr pointer = 0 (requester 0 favoured), and all scoreboard entries are invalid.
- Reset mid-operation discards scoreboard tracking immediately.
- Operand use by func:
  - 0, 1, 2, 5, 6, 7 read rs1 and rs2.
  - 3, 8, 10, 11 read rs1 only.
  - 4, 9 read rs2 only.
  - 12-15 are illegal.
- Hazard: a requester is blocked if any operand it reads equals rd of a valid scoreboard entry. An unused operand field never blocks.
- Eligibility: valid && !hold && (illegal || !hazard).
- Arbitration:
  - At most one acceptance per cycle.
  - If both requesters are eligible, the rr-favoured one wins.
  - If only one is eligible, it wins regardless of the pointer; a blocked favoured requester does not stall the other.
  - After any acceptance, the pointer points at the non-winner.
- reqN_ready is combinational (may depend on reqN_valid) and is high only in the acceptance cycle.
- Legal acceptance in cycle t:
  - iss_* are registered: iss_valid = 1 for exactly cycle t+1 with the accepted fields.
  - issue_cnt increments at t+1.
  - The scoreboard entry {1, rd} is inserted.
- Illegal acceptance in cycle t:
  - No issue.
  - err_pulse = 1 at t+1; err_cnt increments (saturating).
  - Nothing is inserted in the scoreboard.
  - The pointer still advances.
- Scoreboard:
  - Shift register of WB_LAT entries, shifting every cycle; the newest entry is inserted at the head.
  - An entry blocks from the cycle after acceptance through WB_LAT cycles after acceptance inclusive. A dependent is therefore accepted no earlier than t+WB_LAT+1.
  - Acceptance does not check its own rd against the same-cycle insertion; WAW ordering is preserved by in-order issue.
- iss_* fields other than iss_valid retain their last value when iss_valid = 0.
- hold high: no ready and no new issue; the scoreboard keeps shifting (drains).

Decomposition:
- Shared package pipe_pkg holds:
  - func code constants (FN_ADD = 0 .. FN_SHL = 11), FN_LAST = 11;
  - instruction field offsets;
  - the operand-use decode function uses_rs1/uses_rs2.
- One sub-module, pipe_scoreboard: shift register plus two-operand match, outputs hazard flags per requester.

Test Plan:
- Reset mid-traffic: assert rst with both requesters pending -> outputs 0 immediately; after release, requester 0 wins first.
- Round-robin:
  - Stimulus: both requesters always valid with independent instructions (req0 ADD rd=1 rs=8,9; req1 ADD rd=2 rs=10,11).
  - Required response: grants alternate 0,1,0,1; iss_src matches; issue_cnt = 4 after 4 issues.
- RAW stall:
  - Stimulus: req0 issues ADD rd=5 at cycle t; then req0 presents SUB rs1=5.
  - Required response: ready low t+1..t+3; accepted at t+4 (WB_LAT = 3).
  - Concurrently req1 independent -> req1 granted during the stall.
- Unused operand: after rd=5 in flight, func=3 with rs2=5, rs1=0 -> accepted with no stall.
- Illegal func:
  - Stimulus: req1 func=13 at cycle t.
  - Required response: req1_ready high at t; iss_valid low at t+1; err_pulse at t+1; err_cnt = 1; scoreboard unchanged.
- Hold and saturation:
  - hold = 1 for 5 cycles with valid requests -> no ready, busy falls to 0 once the scoreboard drains.
  - Force err_cnt to 16'hFFFF then drop another illegal -> err_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the issue controller: func codes, instruction layout, operand-use decode.
package pipe_pkg;

    localparam int unsigned INSTR_BITS = 24;
    localparam int unsigned FUNC_W     = 4;
    localparam int unsigned REG_W      = 4;
    localparam int unsigned ADDR_W     = 8;

    localparam int unsigned FUNC_LSB = 20;
    localparam int unsigned RD_LSB   = 16;
    localparam int unsigned RS1_LSB  = 12;
    localparam int unsigned RS2_LSB  = 8;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FN_AND = 4'd2;
    localparam logic [FUNC_W-1:0] FN_MOV = 4'd3;
    localparam logic [FUNC_W-1:0] FN_NEG = 4'd4;
    localparam logic [FUNC_W-1:0] FN_OR  = 4'd5;
    localparam logic [FUNC_W-1:0] FN_XOR = 4'd6;
    localparam logic [FUNC_W-1:0] FN_CMP = 4'd7;
    localparam logic [FUNC_W-1:0] FN_LD  = 4'd8;
    localparam logic [FUNC_W-1:0] FN_ST  = 4'd9;
    localparam logic [FUNC_W-1:0] FN_SHR = 4'd10;
    localparam logic [FUNC_W-1:0] FN_SHL = 4'd11;
    localparam logic [FUNC_W-1:0] FN_LAST = FN_SHL;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // Round-robin pointer: which requester wins a tie.
    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_e;

    function automatic instr_t unpack_instr(input logic [INSTR_BITS-1:0] w);
        instr_t r;
        r.func = w[FUNC_LSB +: FUNC_W];
        r.rd   = w[RD_LSB   +: REG_W];
        r.rs1  = w[RS1_LSB  +: REG_W];
        r.rs2  = w[RS2_LSB  +: REG_W];
        r.addr = w[ADDR_LSB +: ADDR_W];
        return r;
    endfunction

    function automatic logic is_illegal(input logic [FUNC_W-1:0] f);
        return f > FN_LAST;
    endfunction

    function automatic logic uses_rs1(input logic [FUNC_W-1:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_CMP,
            FN_MOV, FN_LD, FN_SHR, FN_SHL: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [FUNC_W-1:0] f);
        case (f)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_CMP,
            FN_NEG, FN_ST: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination tracker: WB_LAT-deep shift register with per-requester RAW match.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned WB_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ins_valid,
    input  logic [REG_W-1:0]  ins_rd,
    input  logic [FUNC_W-1:0] func0,
    input  logic [REG_W-1:0]  rs1_0,
    input  logic [REG_W-1:0]  rs2_0,
    input  logic [FUNC_W-1:0] func1,
    input  logic [REG_W-1:0]  rs1_1,
    input  logic [REG_W-1:0]  rs2_1,
    output logic              hazard0,
    output logic              hazard1,
    output logic              busy_next
);

    logic [WB_LAT-1:0] valid_q;
    logic [REG_W-1:0]  rd_q [WB_LAT];

    // Shift every cycle; newest acceptance enters at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(WB_LAT); i++) begin
                rd_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= ins_valid;
            rd_q[0]    <= ins_rd;
            for (int i = 1; i < int'(WB_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                rd_q[i]    <= rd_q[i-1];
            end
        end
    end

    // Only operands the func actually reads can collide with an in-flight rd.
    always_comb begin
        hazard0 = 1'b0;
        hazard1 = 1'b0;
        for (int i = 0; i < int'(WB_LAT); i++) begin
            if (valid_q[i]) begin
                if ((uses_rs1(func0) && rs1_0 == rd_q[i]) ||
                    (uses_rs2(func0) && rs2_0 == rd_q[i])) begin
                    hazard0 = 1'b1;
                end
                if ((uses_rs1(func1) && rs1_1 == rd_q[i]) ||
                    (uses_rs2(func1) && rs2_1 == rd_q[i])) begin
                    hazard1 = 1'b1;
                end
            end
        end
    end

    // Occupancy after the next edge: the insertion plus every entry not yet at the tail.
    always_comb begin
        busy_next = ins_valid;
        for (int i = 0; i + 1 < int'(WB_LAT); i++) begin
            busy_next = busy_next | valid_q[i];
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Two-requester round-robin issue controller with RAW hold-off and illegal-op drop.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned INSTR_W = 24,
    parameter int unsigned WB_LAT  = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [INSTR_W-1:0] req0_instr,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [INSTR_W-1:0] req1_instr,
    output logic               req1_ready,
    input  logic               hold,
    output logic               iss_valid,
    output logic [REG_W-1:0]   iss_rs1,
    output logic [REG_W-1:0]   iss_rs2,
    output logic [REG_W-1:0]   iss_rd,
    output logic [FUNC_W-1:0]  iss_func,
    output logic [ADDR_W-1:0]  iss_addr,
    output logic               iss_src,
    output logic               busy,
    output logic               err_pulse,
    output logic [CNT_W-1:0]   issue_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    instr_t ins0;
    instr_t ins1;
    instr_t sel;
    logic   ill0, ill1, haz0, haz1;
    logic   elig0, elig1, grant0, grant1;
    logic   accept, sel_ill, legal_acc, sb_busy_next;
    rr_e    rr_q, rr_d;

    assign ins0 = unpack_instr(req0_instr);
    assign ins1 = unpack_instr(req1_instr);
    assign ill0 = is_illegal(ins0.func);
    assign ill1 = is_illegal(ins1.func);

    pipe_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .ins_valid (legal_acc),
        .ins_rd    (sel.rd),
        .func0     (ins0.func),
        .rs1_0     (ins0.rs1),
        .rs2_0     (ins0.rs2),
        .func1     (ins1.func),
        .rs1_1     (ins1.rs1),
        .rs2_1     (ins1.rs2),
        .hazard0   (haz0),
        .hazard1   (haz1),
        .busy_next (sb_busy_next)
    );

    // Eligibility and arbitration; a lone eligible requester wins regardless of the pointer.
    always_comb begin
        elig0     = req0_valid && !hold && (ill0 || !haz0);
        elig1     = req1_valid && !hold && (ill1 || !haz1);
        grant0    = elig0 && (!elig1 || rr_q == RR_REQ0);
        grant1    = elig1 && (!elig0 || rr_q == RR_REQ1);
        accept    = grant0 || grant1;
        sel       = grant1 ? ins1 : ins0;
        sel_ill   = grant1 ? ill1 : ill0;
        legal_acc = accept && !sel_ill;
    end

    // Pointer moves to the non-winner after any acceptance, legal or not.
    always_comb begin
        rr_d = rr_q;
        if (grant0) begin
            rr_d = RR_REQ1;
        end else if (grant1) begin
            rr_d = RR_REQ0;
        end
    end

    // Ready is the acceptance strobe itself; forced low while reset is asserted.
    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;

    // Issue registers, counters and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_REQ0;
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
            iss_src   <= 1'b0;
            busy      <= 1'b0;
            err_pulse <= 1'b0;
            issue_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            rr_q      <= rr_d;
            iss_valid <= legal_acc;
            err_pulse <= accept && sel_ill;
            busy      <= legal_acc || sb_busy_next;
            if (legal_acc) begin
                iss_rs1   <= sel.rs1;
                iss_rs2   <= sel.rs2;
                iss_rd    <= sel.rd;
                iss_func  <= sel.func;
                iss_addr  <= sel.addr;
                iss_src   <= grant1;
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (accept && sel_ill && err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Self-checking bench for pipe_issue_ctrl: directed table, reset/saturation sequences, random vs model.
module tb_pipe_issue_ctrl;

    localparam int unsigned WB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, hold;
    logic [23:0] in0, in1;
    logic        r0, r1, iss_valid, iss_src, busy, err_pulse;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic [15:0] issue_cnt, err_cnt;

    // Second instance with narrow counters for the saturation check.
    logic        s_v1;
    logic [23:0] s_in1;
    logic        s_r0, s_r1, s_iv, s_src, s_busy, s_ep;
    logic [3:0]  s_rs1, s_rs2, s_rd, s_func;
    logic [7:0]  s_addr;
    logic [3:0]  s_icnt, s_ecnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_issue_ctrl #(.INSTR_W(24), .WB_LAT(WB_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_instr(in0), .req0_ready(r0),
        .req1_valid(v1), .req1_instr(in1), .req1_ready(r1),
        .hold(hold),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr), .iss_src(iss_src),
        .busy(busy), .err_pulse(err_pulse), .issue_cnt(issue_cnt), .err_cnt(err_cnt)
    );

    pipe_issue_ctrl #(.INSTR_W(24), .WB_LAT(WB_LAT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(1'b0), .req0_instr(24'h0), .req0_ready(s_r0),
        .req1_valid(s_v1), .req1_instr(s_in1), .req1_ready(s_r1),
        .hold(1'b0),
        .iss_valid(s_iv), .iss_rs1(s_rs1), .iss_rs2(s_rs2), .iss_rd(s_rd),
        .iss_func(s_func), .iss_addr(s_addr), .iss_src(s_src),
        .busy(s_busy), .err_pulse(s_ep), .issue_cnt(s_icnt), .err_cnt(s_ecnt)
    );

    // ---------------- reference model ----------------
    typedef struct { logic [3:0] rd; int t; } inflight_t;
    inflight_t   infl[$];
    int          cyc = 0;
    bit          m_rr;
    logic        e_iv, e_ep, e_src;
    logic [3:0]  e_rs1, e_rs2, e_rd, e_func;
    logic [7:0]  e_addr;
    logic [15:0] e_icnt, e_ecnt;

    function automatic logic [23:0] mk(input int f, input int rd, input int a, input int b, input int ad);
        return {4'(f), 4'(rd), 4'(a), 4'(b), 8'(ad)};
    endfunction

    function automatic bit reads1(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11};
    endfunction

    function automatic bit reads2(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    endfunction

    function automatic bit illegal(input logic [23:0] x);
        return x[23:20] >= 4'd12;
    endfunction

    function automatic bit blocked(input logic [23:0] x);
        foreach (infl[k]) begin
            if (cyc - infl[k].t >= 1 && cyc - infl[k].t <= int'(WB_LAT)) begin
                if ((reads1(x[23:20]) && x[15:12] == infl[k].rd) ||
                    (reads2(x[23:20]) && x[11:8]  == infl[k].rd)) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_rr = 1'b0;
        infl.delete();
        e_iv = 0; e_ep = 0; e_src = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_func = 0; e_addr = 0;
        e_icnt = 0; e_ecnt = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive at posedge+2, check ready, clock, check registered outputs at posedge+2.
    task automatic step(input bit a0, input logic [23:0] x0, input bit a1, input logic [23:0] x1,
                        input bit h, output bit g0, output bit g1, output bit ar0, output bit ar1);
        bit el0, el1;
        logic [23:0] s;
        v0 = a0; in0 = x0; v1 = a1; in1 = x1; hold = h;
        #2;
        el0 = a0 && !h && (illegal(x0) || !blocked(x0));
        el1 = a1 && !h && (illegal(x1) || !blocked(x1));
        g0 = el0 && (!el1 || !m_rr);
        g1 = el1 && (!el0 || m_rr);
        ar0 = r0; ar1 = r1;
        check("ready0", 32'(r0), 32'(g0));
        check("ready1", 32'(r1), 32'(g1));
        @(posedge clk);
        s = g1 ? x1 : x0;
        e_iv = 1'b0; e_ep = 1'b0;
        if (g0 || g1) begin
            m_rr = g0;
            if (illegal(s)) begin
                e_ep = 1'b1;
                if (e_ecnt != 16'hFFFF) e_ecnt = e_ecnt + 16'd1;
            end else begin
                infl.push_back('{rd: s[19:16], t: cyc});
                e_iv = 1'b1; e_src = g1;
                e_func = s[23:20]; e_rd = s[19:16]; e_rs1 = s[15:12]; e_rs2 = s[11:8]; e_addr = s[7:0];
                e_icnt = e_icnt + 16'd1;
            end
        end
        cyc++;
        while (infl.size() > 0 && cyc - infl[0].t > int'(WB_LAT)) void'(infl.pop_front());
        #2;
        check("iss_valid", 32'(iss_valid), 32'(e_iv));
        check("err_pulse", 32'(err_pulse), 32'(e_ep));
        check("issue_cnt", 32'(issue_cnt), 32'(e_icnt));
        check("err_cnt",   32'(err_cnt),   32'(e_ecnt));
        check("busy",      32'(busy),      32'(e_iv || infl.size() > 0));
        check("iss_fields", {iss_src, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr},
                            {e_src, e_func, e_rd, e_rs1, e_rs2, e_addr});
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit v0; logic [23:0] x0; bit v1; logic [23:0] x1; bit h; bit r0; bit r1;
    } vec_t;
    vec_t tbl[17];

    initial begin
        logic [23:0] A, B, C, D, M, X, p0, p1;
        bit g0, g1, ar0, ar1, pv0, pv1, ph;

        A = mk(0, 1, 8, 9, 8'h10);
        B = mk(0, 2, 10, 11, 8'h20);
        C = mk(0, 5, 8, 9, 8'h30);
        D = mk(1, 6, 5, 9, 8'h40);
        M = mk(3, 7, 0, 6, 8'h50);
        X = mk(13, 7, 1, 1, 8'h60);

        tbl[0]  = '{1, A, 1, B, 0, 1, 0};
        tbl[1]  = '{1, A, 1, B, 0, 0, 1};
        tbl[2]  = '{1, A, 1, B, 0, 1, 0};
        tbl[3]  = '{1, A, 1, B, 0, 0, 1};
        tbl[4]  = '{1, C, 0, B, 0, 1, 0};
        tbl[5]  = '{1, D, 1, B, 0, 0, 1};
        tbl[6]  = '{1, D, 1, B, 0, 0, 1};
        tbl[7]  = '{1, D, 1, B, 0, 0, 1};
        tbl[8]  = '{1, D, 1, B, 0, 1, 0};
        tbl[9]  = '{1, M, 0, B, 0, 1, 0};
        tbl[10] = '{0, A, 1, X, 0, 0, 1};
        for (int i = 11; i <= 15; i++) tbl[i] = '{1, A, 1, B, 1, 0, 0};
        tbl[16] = '{1, A, 1, B, 0, 1, 0};

        s_v1 = 1'b0; s_in1 = X;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; in0 = A; in1 = B; hold = 1'b0;
        model_reset();
        @(posedge clk); #2;
        check("rst_ready0", 32'(r0), 32'(0));
        check("rst_ready1", 32'(r1), 32'(0));
        check("rst_iss_valid", 32'(iss_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cnts", {issue_cnt, err_cnt}, 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v0, tbl[i].x0, tbl[i].v1, tbl[i].x1, tbl[i].h, g0, g1, ar0, ar1);
            check($sformatf("tbl%0d_r0", i), 32'(ar0), 32'(tbl[i].r0));
            check($sformatf("tbl%0d_r1", i), 32'(ar1), 32'(tbl[i].r1));
            if (i == 3)  check("rr_issue_cnt", 32'(issue_cnt), 32'(4));
            if (i == 10) check("illegal_err_cnt", 32'(err_cnt), 32'(1));
            if (i == 15) check("hold_drained_busy", 32'(busy), 32'(0));
        end

        // Reset mid-traffic: outputs clear at once, requester 0 wins first afterwards.
        step(1, C, 1, B, 0, g0, g1, ar0, ar1);
        rst = 1'b1;
        #1;
        check("midrst_iss_valid", 32'(iss_valid), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_cnts", {issue_cnt, err_cnt}, 32'(0));
        check("midrst_ready", {r0, r1}, 32'(0));
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, D, 1, B, 0, g0, g1, ar0, ar1);
        check("postrst_first_r0", 32'(ar0), 32'(1));

        // Randomized traffic against the model; instructions stay stable until accepted.
        pv0 = 0; pv1 = 0; p0 = 0; p1 = 0; g0 = 0; g1 = 0;
        for (int n = 0; n < 500; n++) begin
            if (!pv0 || g0) begin
                pv0 = $urandom_range(0, 3) != 0;
                p0  = mk(int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            end
            if (!pv1 || g1) begin
                pv1 = $urandom_range(0, 3) != 0;
                p1  = mk(int'($urandom_range(0, 13)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            end
            ph = $urandom_range(0, 9) == 0;
            step(pv0, p0, pv1, p1, ph, g0, g1, ar0, ar1);
        end
        v0 = 1'b0; v1 = 1'b0;

        // Saturation: a 4-bit error counter must stick at all-ones.
        s_v1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #2;
            check($sformatf("sat_err_cnt_%0d", k), 32'(s_ecnt), 32'((k < 15) ? k : 15));
            check($sformatf("sat_err_pulse_%0d", k), 32'(s_ep), 32'(1));
        end
        check("sat_no_issue", 32'(s_icnt), 32'(0));
        s_v1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
